// File: rtl/draw_pkg.sv
// Shared types and constants for the sprite blitter: FSM encoding, scale codes, pixel width.
// Scale code 3 is treated as x4 so every 2-bit value maps to a valid shift.
package draw_pkg;

  localparam int RGB565_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_ADVANCE,
    ST_DONE
  } state_t;

  localparam logic [1:0] SCALE_X1     = 2'd0;
  localparam logic [1:0] SCALE_X2     = 2'd1;
  localparam logic [1:0] SCALE_X4     = 2'd2;
  localparam logic [1:0] SCALE_X4_ALT = 2'd3;

  function automatic logic [1:0] scale_shift(input logic [1:0] code);
    logic [1:0] sh;
    sh = 2'd0;
    case (code)
      SCALE_X1:     sh = 2'd0;
      SCALE_X2:     sh = 2'd1;
      SCALE_X4:     sh = 2'd2;
      SCALE_X4_ALT: sh = 2'd2;
      default:      sh = 2'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Maps destination offsets (dx,dy) to a source ROM word address, applying scale and mirror.
// Purely combinational; address wraps modulo 2^ADDR_WIDTH.
module sprite_addr_gen #(
  parameter int ADDR_WIDTH = 17,
  parameter int DIM_WIDTH  = 9,
  parameter int CW         = DIM_WIDTH + 2
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [CW-1:0]         dx,
  input  logic [CW-1:0]         dy,
  input  logic [1:0]            shift,
  input  logic                  mirror,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [DIM_WIDTH-1:0]   sx_raw;
  logic [DIM_WIDTH-1:0]   sx;
  logic [DIM_WIDTH-1:0]   sy;
  logic [2*DIM_WIDTH-1:0] row_off;

  // dx < width<<shift, so the shifted column always fits in DIM_WIDTH bits
  assign sx_raw  = DIM_WIDTH'(dx >> shift);
  assign sx      = mirror ? (width - DIM_WIDTH'(1) - sx_raw) : sx_raw;
  assign sy      = DIM_WIDTH'(dy >> shift);
  assign row_off = {{DIM_WIDTH{1'b0}}, sy} * {{DIM_WIDTH{1'b0}}, width};
  assign addr    = base + ADDR_WIDTH'(row_off) + ADDR_WIDTH'(sx);

endmodule

// File: rtl/draw_sprite_engine.sv
// Sprite blitter: reads a ROM image and writes scaled/mirrored/keyed pixels with screen clipping.
// Four cycles per pixel (FETCH/WAIT/EMIT/ADVANCE); EMIT holds until pixelReady, abort wins.
module draw_sprite_engine
  import draw_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 240,
  parameter int SCREEN_HEIGHT = 320,
  parameter int ADDR_WIDTH    = 17,
  parameter int DIM_WIDTH     = 9,
  parameter int COLOR_WIDTH   = RGB565_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   draw,
  input  logic                   abort,
  input  logic [15:0]            xOrigin,
  input  logic [15:0]            yOrigin,
  input  logic [ADDR_WIDTH-1:0]  imgBase,
  input  logic [DIM_WIDTH-1:0]   imgWidth,
  input  logic [DIM_WIDTH-1:0]   imgHeight,
  input  logic [1:0]             scale,
  input  logic                   mirror,
  input  logic                   keyEnable,
  input  logic [COLOR_WIDTH-1:0] keyColour,
  output logic [ADDR_WIDTH-1:0]  romAddr,
  input  logic [COLOR_WIDTH-1:0] romData,
  output logic [7:0]             pixelX,
  output logic [8:0]             pixelY,
  output logic [COLOR_WIDTH-1:0] pixelData,
  output logic                   pixelWrite,
  input  logic                   pixelReady,
  output logic                   ready,
  output logic                   done
);

  localparam int CW = DIM_WIDTH + 2;

  state_t state, state_nxt;

  logic [15:0]            x_org, y_org;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [DIM_WIDTH-1:0]   width_q, height_q;
  logic [1:0]             shift_q;
  logic                   mirror_q, key_en_q, skip_q;
  logic [COLOR_WIDTH-1:0] key_col_q;
  logic [CW-1:0]          dx, dy, w_tot, h_tot;
  logic [16:0]            x_sum, y_sum;
  logic [ADDR_WIDTH-1:0]  gen_addr;
  logic                   last_col, last_row, accept, clip;

  sprite_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DIM_WIDTH (DIM_WIDTH),
    .CW        (CW)
  ) u_addr_gen (
    .base  (base_q),
    .width (width_q),
    .dx    (dx),
    .dy    (dy),
    .shift (shift_q),
    .mirror(mirror_q),
    .addr  (gen_addr)
  );

  assign accept   = (state == ST_IDLE) && draw;
  assign w_tot    = CW'(width_q) << shift_q;
  assign h_tot    = CW'(height_q) << shift_q;
  assign last_col = (dx == w_tot - CW'(1));
  assign last_row = (dy == h_tot - CW'(1));
  assign x_sum    = {1'b0, x_org} + 17'(dx);
  assign y_sum    = {1'b0, y_org} + 17'(dy);
  assign clip     = (x_sum >= 17'(SCREEN_WIDTH)) || (y_sum >= 17'(SCREEN_HEIGHT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    done       = 1'b0;
    pixelWrite = 1'b0;
    romAddr    = '0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (draw) begin
          if (imgWidth == '0 || imgHeight == '0) state_nxt = ST_DONE;
          else                                   state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        romAddr   = gen_addr;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (skip_q) state_nxt = ST_ADVANCE;
        else begin
          pixelWrite = 1'b1;
          if (pixelReady) state_nxt = ST_ADVANCE;
        end
      end
      ST_ADVANCE: state_nxt = (last_col && last_row) ? ST_DONE : ST_FETCH;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // abort overrides any pending handshake, including a ready LCD write
    if (state != ST_IDLE && abort) begin
      state_nxt  = ST_IDLE;
      pixelWrite = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_org     <= '0;
      y_org     <= '0;
      base_q    <= '0;
      width_q   <= '0;
      height_q  <= '0;
      shift_q   <= '0;
      mirror_q  <= 1'b0;
      key_en_q  <= 1'b0;
      key_col_q <= '0;
      dx        <= '0;
      dy        <= '0;
      skip_q    <= 1'b0;
      pixelX    <= '0;
      pixelY    <= '0;
      pixelData <= '0;
    end else begin
      if (accept) begin
        x_org     <= xOrigin;
        y_org     <= yOrigin;
        base_q    <= imgBase;
        width_q   <= imgWidth;
        height_q  <= imgHeight;
        shift_q   <= scale_shift(scale);
        mirror_q  <= mirror;
        key_en_q  <= keyEnable;
        key_col_q <= keyColour;
        dx        <= '0;
        dy        <= '0;
      end
      // ROM word addressed in FETCH is valid here; register it so EMIT outputs stay put
      if (state == ST_WAIT) begin
        pixelX    <= x_sum[7:0];
        pixelY    <= y_sum[8:0];
        pixelData <= romData;
        skip_q    <= clip || (key_en_q && (romData == key_col_q));
      end
      if (state == ST_ADVANCE && !abort) begin
        if (last_col) begin
          dx <= '0;
          dy <= dy + CW'(1);
        end else begin
          dx <= dx + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_sprite_engine.sv
// Scoreboard bench for draw_sprite_engine: a reference model queues expected writes per request.
// A negedge monitor pops and compares every completed pixel handshake.
module tb_draw_sprite_engine;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pix_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        draw = 1'b0, abort = 1'b0;
  logic [15:0] xOrigin = '0, yOrigin = '0;
  logic [16:0] imgBase = '0;
  logic [8:0]  imgWidth = '0, imgHeight = '0;
  logic [1:0]  scale = '0;
  logic        mirror = 1'b0, keyEnable = 1'b0;
  logic [15:0] keyColour = '0;
  logic [16:0] romAddr;
  logic [15:0] romData = '0;
  logic [7:0]  pixelX;
  logic [8:0]  pixelY;
  logic [15:0] pixelData;
  logic        pixelWrite, pixelReady = 1'b1, ready, done;

  int   n_chk = 0, n_bad = 0;
  int   write_cnt = 0, done_cnt = 0, rom_nz = 0;
  pix_t exp_q[$];
  logic        key_on = 1'b0;
  logic [16:0] key_addr = '0;

  draw_sprite_engine dut (
    .clock(clock), .reset(reset), .draw(draw), .abort(abort),
    .xOrigin(xOrigin), .yOrigin(yOrigin), .imgBase(imgBase),
    .imgWidth(imgWidth), .imgHeight(imgHeight), .scale(scale), .mirror(mirror),
    .keyEnable(keyEnable), .keyColour(keyColour), .romAddr(romAddr), .romData(romData),
    .pixelX(pixelX), .pixelY(pixelY), .pixelData(pixelData), .pixelWrite(pixelWrite),
    .pixelReady(pixelReady), .ready(ready), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] rom_word(input logic [16:0] a);
    if (key_on && a == key_addr) return 16'hF81F;
    return 16'(int'(a) * 37 + 5);
  endfunction

  always @(posedge clock) romData <= rom_word(romAddr);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (pixelWrite && pixelReady) begin
        write_cnt++;
        check_val("exp_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_val("pixel", {pixelX, pixelY, pixelData}, exp_q.pop_front());
      end
      if (done) done_cnt++;
      if (romAddr != '0) rom_nz++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // reference model: raster walk of the scaled destination rectangle
  task automatic push_model(input int x0, input int y0, input int base, input int w, input int h,
                            input int sc, input bit mir, input bit ke, input logic [15:0] kc);
    int s;
    int sx, sy, x, y;
    logic [16:0] a;
    logic [15:0] d;
    pix_t p;
    s = (sc == 0) ? 1 : (sc == 1) ? 2 : 4;
    for (int dy = 0; dy < h * s; dy++) begin
      for (int dx = 0; dx < w * s; dx++) begin
        sx = mir ? (w - 1 - dx / s) : (dx / s);
        sy = dy / s;
        a  = 17'(base + sy * w + sx);
        d  = rom_word(a);
        x  = x0 + dx;
        y  = y0 + dy;
        if (x < 240 && y < 320 && !(ke && d == kc)) begin
          p.x = 8'(x); p.y = 9'(y); p.d = d;
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic start_draw(input int x0, input int y0, input int base, input int w, input int h,
                            input int sc, input bit mir, input bit ke, input logic [15:0] kc);
    push_model(x0, y0, base, w, h, sc, mir, ke, kc);
    xOrigin = 16'(x0); yOrigin = 16'(y0); imgBase = 17'(base);
    imgWidth = 9'(w); imgHeight = 9'(h); scale = 2'(sc); mirror = mir;
    keyEnable = ke; keyColour = kc;
    draw = 1'b1;
    tick();
    draw = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) tick();
    check_val({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic run_case(input string tag, input int x0, input int y0, input int base,
                          input int w, input int h, input int sc, input bit mir,
                          input bit ke, input logic [15:0] kc, input int exp_writes);
    int w0, d0;
    w0 = write_cnt;
    d0 = done_cnt;
    check_val({tag, "_ready"}, 64'(ready), 64'd1);
    start_draw(x0, y0, base, w, h, sc, mir, ke, kc);
    wait_done(tag);
    tick(); tick();
    check_val({tag, "_writes"}, 64'(write_cnt - w0), 64'(exp_writes));
    check_val({tag, "_dones"}, 64'(done_cnt - d0), 64'd1);
    check_val({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 64'(ready), 64'd1);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_pwrite"}, 64'(pixelWrite), 64'd0);
    check_val({tag, "_romaddr"}, 64'(romAddr), 64'd0);
    check_val({tag, "_pix"}, {pixelX, pixelY, pixelData}, 64'd0);
  endtask

  initial begin
    pix_t held;
    int w0, d0;
    #2;
    check_reset_outputs("rst");
    tick();
    reset = 1'b1;
    tick();

    run_case("basic4x3", 10, 10, 0, 4, 3, 0, 1'b0, 1'b0, 16'h0, 12);
    run_case("mirror2x", 0, 0, 0, 2, 2, 1, 1'b1, 1'b0, 16'h0, 16);
    run_case("clip", 238, 319, 8, 4, 1, 0, 1'b0, 1'b0, 16'h0, 2);
    key_on = 1'b1; key_addr = 17'h22;
    run_case("key", 5, 5, 32'h20, 4, 1, 0, 1'b0, 1'b1, 16'hF81F, 3);
    key_on = 1'b0;
    run_case("x4", 100, 50, 3, 2, 1, 3, 1'b0, 1'b0, 16'h0, 32);

    // stall the first write, then abort mid-image
    pixelReady = 1'b0;
    d0 = done_cnt;
    start_draw(0, 0, 32'h40, 4, 1, 0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 50 && !pixelWrite; i++) tick();
    check_val("stall_wr_seen", 64'(pixelWrite), 64'd1);
    held = {pixelX, pixelY, pixelData};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("stall_wr_held", 64'(pixelWrite), 64'd1);
      check_val("stall_out_held", {pixelX, pixelY, pixelData}, held);
    end
    w0 = write_cnt;
    pixelReady = 1'b1;
    for (int i = 0; i < 50 && write_cnt < w0 + 2; i++) tick();
    check_val("pre_abort_writes", 64'(write_cnt - w0), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_ready", 64'(ready), 64'd1);
    check_val("abort_pwrite", 64'(pixelWrite), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check_val("abort_no_done", 64'(done_cnt - d0), 64'd0);
    exp_q.delete();

    // reset in the middle of a draw
    d0 = done_cnt;
    start_draw(20, 30, 0, 4, 3, 0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 200 && write_cnt < w0 + 5; i++) tick();
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    tick();
    reset = 1'b1;
    w0 = write_cnt;
    for (int i = 0; i < 20; i++) tick();
    check_val("midrst_no_writes", 64'(write_cnt - w0), 64'd0);
    check_val("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    rom_nz = 0;
    run_case("zero_w", 7, 7, 32'h55, 0, 3, 0, 1'b0, 1'b0, 16'h0, 0);
    check_val("zero_w_rom_reads", 64'(rom_nz), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
